// File: rtl/md_sched_pkg.sv
// Shared definitions for the metadata scheduler: FSM encoding, queue ids
// and the token counter width.
package md_sched_pkg;

   localparam int TOKEN_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   localparam logic [1:0] QID_0 = 2'd0;
   localparam logic [1:0] QID_1 = 2'd1;
   localparam logic [1:0] QID_2 = 2'd2;
   localparam logic [1:0] QID_3 = 2'd3;

endpackage

// File: rtl/ms_token_bucket.sv
// Token bucket for queue 2 credit shaping.
// Build option: MS_RC_SHAPING_EN. When defined, a 7-bit bucket refills one
// token every TOKEN_PERIOD clocks (saturating at TOKEN_MAX) and is debited by
// the cost of each q2 pop. When undefined, the counter and divider are absent
// and the bucket reports a constant full level.
module ms_token_bucket
   import md_sched_pkg::*;
#(
   parameter int TOKEN_MAX    = 127,
   parameter int TOKEN_PERIOD = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_consume,
   input  logic [TOKEN_W-1:0] i_cost,
   output logic [TOKEN_W-1:0] o_tokens
);

`ifdef MS_RC_SHAPING_EN
   localparam int                 DIV_W    = (TOKEN_PERIOD > 1) ? $clog2(TOKEN_PERIOD) : 1;
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TOKEN_PERIOD - 1);
   localparam logic [TOKEN_W:0]   SAT      = (TOKEN_W + 1)'(TOKEN_MAX);

   logic [DIV_W-1:0]   r_div;
   logic [TOKEN_W-1:0] r_tokens;
   logic               w_refill;
   logic [TOKEN_W:0]   w_sum;
   logic [TOKEN_W-1:0] w_tok_nxt;

   assign w_refill = (r_div == DIV_LAST);

   // Next token level: debit on pop, credit on refill, clamp at the ceiling.
   // A pop is only ever issued when tokens >= cost, so the debit never wraps.
   always_comb begin
      w_sum     = {1'b0, r_tokens};
      w_tok_nxt = r_tokens;
      if (i_consume) begin
         w_sum = w_sum - {1'b0, i_cost};
      end else begin
         w_sum = w_sum;
      end
      if (w_refill) begin
         w_sum = w_sum + {{TOKEN_W{1'b0}}, 1'b1};
      end else begin
         w_sum = w_sum;
      end
      if (w_sum > SAT) begin
         w_tok_nxt = SAT[TOKEN_W-1:0];
      end else begin
         w_tok_nxt = w_sum[TOKEN_W-1:0];
      end
   end

   // Token level and refill divider; bucket starts full after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tokens <= SAT[TOKEN_W-1:0];
         r_div    <= {DIV_W{1'b0}};
      end else begin
         r_tokens <= w_tok_nxt;
         if (w_refill) begin
            r_div <= {DIV_W{1'b0}};
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   assign o_tokens = r_tokens;
`else
   logic w_unused_inputs;

   assign o_tokens        = TOKEN_W'(TOKEN_MAX);
   assign w_unused_inputs = ^{clk, rst_n, i_consume, i_cost};
`endif

endmodule

// File: rtl/md_sched.sv
// Metadata scheduler: strict-priority pick among four FWFT queues
// (slot TSN queue > shaped q2 > best-effort q3), one packet in flight at a
// time, released by tx_done from the output port.
// Build option: MS_RC_SHAPING_EN enables token-bucket gating of q2.
module md_sched
   import md_sched_pkg::*;
#(
   parameter string PLATFORM     = "xilinx",
   parameter int    TOKEN_MAX    = 127,
   parameter int    TOKEN_PERIOD = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_ms_time_slot_flag,
   input  logic        in_ms_md0_empty,
   input  logic        in_ms_md1_empty,
   input  logic        in_ms_md2_empty,
   input  logic        in_ms_md3_empty,
   input  logic [8:0]  in_ms_md0,
   input  logic [8:0]  in_ms_md1,
   input  logic [15:0] in_ms_md2,
   input  logic [8:0]  in_ms_md3,
   input  logic        in_ms_tx_done,
   output logic        out_ms_md0_rd,
   output logic        out_ms_md1_rd,
   output logic        out_ms_md2_rd,
   output logic        out_ms_md3_rd,
   output logic [8:0]  out_ms_md,
   output logic        out_ms_md_wr,
   output logic [1:0]  out_ms_md_qid
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic               r_wr;
   logic [8:0]         r_md;
   logic [1:0]         r_qid;
   logic [3:0]         w_rd;
   logic               w_pop;
   logic [8:0]         w_sel_md;
   logic [1:0]         w_sel_qid;
   logic [TOKEN_W-1:0] w_cost;
   logic [TOKEN_W-1:0] w_tokens;
   logic               w_q0_elig;
   logic               w_q1_elig;
   logic               w_q2_elig;
   logic               w_q3_elig;

   assign w_cost    = in_ms_md2[15:9];
   assign w_q0_elig = in_ms_time_slot_flag & ~in_ms_md0_empty;
   assign w_q1_elig = ~in_ms_time_slot_flag & ~in_ms_md1_empty;
   assign w_q3_elig = ~in_ms_md3_empty;

`ifdef MS_RC_SHAPING_EN
   assign w_q2_elig = ~in_ms_md2_empty & (w_tokens >= w_cost);
`else
   logic w_unused_tokens;

   assign w_q2_elig       = ~in_ms_md2_empty;
   assign w_unused_tokens = ^w_tokens;
`endif

   ms_token_bucket #(
      .TOKEN_MAX    (TOKEN_MAX),
      .TOKEN_PERIOD (TOKEN_PERIOD)
   ) u_bucket (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_consume (w_rd[2]),
      .i_cost    (w_cost),
      .o_tokens  (w_tokens)
   );

   // Next state and pop selection. Pops only happen in IDLE and are held off
   // while reset is asserted so no strobe escapes during reset.
   always_comb begin
      w_state_nxt = r_state;
      w_rd        = 4'b0000;
      w_pop       = 1'b0;
      w_sel_md    = 9'd0;
      w_sel_qid   = QID_0;
      case (r_state)
         ST_IDLE: begin
            if (!rst_n) begin
               w_state_nxt = ST_IDLE;
            end else if (w_q0_elig) begin
               w_rd[0]     = 1'b1;
               w_pop       = 1'b1;
               w_sel_md    = in_ms_md0;
               w_sel_qid   = QID_0;
               w_state_nxt = ST_SEND;
            end else if (w_q1_elig) begin
               w_rd[1]     = 1'b1;
               w_pop       = 1'b1;
               w_sel_md    = in_ms_md1;
               w_sel_qid   = QID_1;
               w_state_nxt = ST_SEND;
            end else if (w_q2_elig) begin
               w_rd[2]     = 1'b1;
               w_pop       = 1'b1;
               w_sel_md    = in_ms_md2[8:0];
               w_sel_qid   = QID_2;
               w_state_nxt = ST_SEND;
            end else if (w_q3_elig) begin
               w_rd[3]     = 1'b1;
               w_pop       = 1'b1;
               w_sel_md    = in_ms_md3;
               w_sel_qid   = QID_3;
               w_state_nxt = ST_SEND;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SEND: begin
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (in_ms_tx_done) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register plus latched metadata; wr is high exactly in SEND.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_wr    <= 1'b0;
         r_md    <= 9'd0;
         r_qid   <= QID_0;
      end else begin
         r_state <= w_state_nxt;
         r_wr    <= w_pop;
         if (w_pop) begin
            r_md  <= w_sel_md;
            r_qid <= w_sel_qid;
         end
      end
   end

   assign out_ms_md0_rd = w_rd[0];
   assign out_ms_md1_rd = w_rd[1];
   assign out_ms_md2_rd = w_rd[2];
   assign out_ms_md3_rd = w_rd[3];
   assign out_ms_md     = r_md;
   assign out_ms_md_wr  = r_wr;
   assign out_ms_md_qid = r_qid;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched. FWFT queues are bench queues; a
// transaction-level model predicts pops, writes, held outputs and tokens.
module tb_md_sched;

   localparam int TMAX = 127;
   localparam int TPER = 16;

   logic        clk;
   logic        rst_n;
   logic        in_ms_time_slot_flag;
   logic        in_ms_md0_empty, in_ms_md1_empty, in_ms_md2_empty, in_ms_md3_empty;
   logic [8:0]  in_ms_md0, in_ms_md1, in_ms_md3;
   logic [15:0] in_ms_md2;
   logic        in_ms_tx_done;
   logic        out_ms_md0_rd, out_ms_md1_rd, out_ms_md2_rd, out_ms_md3_rd;
   logic [8:0]  out_ms_md;
   logic        out_ms_md_wr;
   logic [1:0]  out_ms_md_qid;

   md_sched dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .in_ms_time_slot_flag (in_ms_time_slot_flag),
      .in_ms_md0_empty      (in_ms_md0_empty),
      .in_ms_md1_empty      (in_ms_md1_empty),
      .in_ms_md2_empty      (in_ms_md2_empty),
      .in_ms_md3_empty      (in_ms_md3_empty),
      .in_ms_md0            (in_ms_md0),
      .in_ms_md1            (in_ms_md1),
      .in_ms_md2            (in_ms_md2),
      .in_ms_md3            (in_ms_md3),
      .in_ms_tx_done        (in_ms_tx_done),
      .out_ms_md0_rd        (out_ms_md0_rd),
      .out_ms_md1_rd        (out_ms_md1_rd),
      .out_ms_md2_rd        (out_ms_md2_rd),
      .out_ms_md3_rd        (out_ms_md3_rd),
      .out_ms_md            (out_ms_md),
      .out_ms_md_wr         (out_ms_md_wr),
      .out_ms_md_qid        (out_ms_md_qid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests;
   int n_fail;

   logic [15:0] q0[$];
   logic [15:0] q1[$];
   logic [15:0] q2[$];
   logic [15:0] q3[$];
   int          dut_log[$];
   logic [3:0]  s_rd;
   logic        s_wr;

   // reference model: a packet is announced the cycle after its pop, then the
   // scheduler is blocked until tx_done is seen after the announcement
   bit          m_wr_due;
   bit          m_blocked;
   logic [8:0]  m_md;
   logic [1:0]  m_qid;
`ifdef MS_RC_SHAPING_EN
   int          m_tokens;
   int          m_cyc;
`endif

   task automatic drive_heads();
      in_ms_md0_empty = (q0.size() == 0);
      in_ms_md1_empty = (q1.size() == 0);
      in_ms_md2_empty = (q2.size() == 0);
      in_ms_md3_empty = (q3.size() == 0);
      in_ms_md0 = (q0.size() > 0) ? q0[0][8:0] : 9'h000;
      in_ms_md1 = (q1.size() > 0) ? q1[0][8:0] : 9'h000;
      in_ms_md2 = (q2.size() > 0) ? q2[0]      : 16'h0000;
      in_ms_md3 = (q3.size() > 0) ? q3[0][8:0] : 9'h000;
   endtask

   task automatic model_reset();
      m_wr_due  = 1'b0;
      m_blocked = 1'b0;
      m_md      = 9'h000;
      m_qid     = 2'd0;
`ifdef MS_RC_SHAPING_EN
      m_tokens  = TMAX;
      m_cyc     = 0;
`endif
   endtask

   // which queue the rules select right now (-1: none)
   function automatic int pick();
      if (in_ms_time_slot_flag && q0.size() > 0) return 0;
      if (!in_ms_time_slot_flag && q1.size() > 0) return 1;
      if (q2.size() > 0) begin
`ifdef MS_RC_SHAPING_EN
         if (int'(q2[0][15:9]) <= m_tokens) return 2;
`else
         return 2;
`endif
      end
      if (q3.size() > 0) return 3;
      return -1;
   endfunction

   function automatic logic [15:0] head_of(input int ch);
      case (ch)
         0: return q0[0];
         1: return q1[0];
         2: return q2[0];
         default: return q3[0];
      endcase
   endfunction

   // one clock: check outputs at negedge, advance the model, pop after edge
   task automatic run_cycle();
      int ch;
      logic [3:0]  exp_rd;
      logic [3:0]  got_rd;
      logic [15:0] head;
      @(negedge clk);
      ch = -1;
      exp_rd = 4'b0000;
      head = 16'h0000;
      if (rst_n === 1'b1 && !m_wr_due && !m_blocked) begin
         ch = pick();
         if (ch >= 0) begin
            exp_rd[ch] = 1'b1;
            head = head_of(ch);
         end
      end
      got_rd = {out_ms_md3_rd, out_ms_md2_rd, out_ms_md1_rd, out_ms_md0_rd};
      n_tests++;
      if (got_rd !== exp_rd) begin
         n_fail++;
         $display("FAIL rd_strobe t=%0t got=%b exp=%b", $time, got_rd, exp_rd);
      end
      n_tests++;
      if (out_ms_md_wr !== m_wr_due) begin
         n_fail++;
         $display("FAIL md_wr t=%0t got=%b exp=%b", $time, out_ms_md_wr, m_wr_due);
      end
      n_tests++;
      if (out_ms_md !== m_md || out_ms_md_qid !== m_qid) begin
         n_fail++;
         $display("FAIL md_qid t=%0t got=%h/%0d exp=%h/%0d", $time, out_ms_md, out_ms_md_qid, m_md, m_qid);
      end
`ifdef MS_RC_SHAPING_EN
      n_tests++;
      if (dut.u_bucket.o_tokens !== 7'(m_tokens)) begin
         n_fail++;
         $display("FAIL tokens t=%0t got=%0d exp=%0d", $time, dut.u_bucket.o_tokens, m_tokens);
      end
`endif
      if (out_ms_md_wr === 1'b1) dut_log.push_back(int'(out_ms_md_qid));
      s_rd = got_rd;
      s_wr = out_ms_md_wr;
      if (rst_n !== 1'b1) begin
         model_reset();
      end else begin
`ifdef MS_RC_SHAPING_EN
         if (ch == 2) m_tokens = m_tokens - int'(head[15:9]);
         if ((m_cyc % TPER) == TPER - 1) m_tokens = m_tokens + 1;
         if (m_tokens > TMAX) m_tokens = TMAX;
         m_cyc++;
`endif
         if (m_blocked && in_ms_tx_done === 1'b1) m_blocked = 1'b0;
         if (m_wr_due) begin
            m_wr_due  = 1'b0;
            m_blocked = 1'b1;
         end
         if (ch >= 0) begin
            m_wr_due = 1'b1;
            m_md     = head[8:0];
            m_qid    = 2'(ch);
         end
      end
      @(posedge clk);
      #1;
      if (s_rd[0] && q0.size() > 0) void'(q0.pop_front());
      if (s_rd[1] && q1.size() > 0) void'(q1.pop_front());
      if (s_rd[2] && q2.size() > 0) void'(q2.pop_front());
      if (s_rd[3] && q3.size() > 0) void'(q3.pop_front());
      drive_heads();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_ms_tx_done = 1'b0;
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
      drive_heads();
      run_cycle();
      run_cycle();
      rst_n = 1'b1;
      dut_log.delete();
   endtask

   task automatic test_reset();
      q3.push_back(16'h0111);
      drive_heads();
      run_cycle();
      run_cycle();
      n_tests++;
      if ({out_ms_md_wr, out_ms_md, out_ms_md_qid, s_rd} !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_outputs wr=%b md=%h qid=%0d rd=%b exp=all zero", out_ms_md_wr, out_ms_md, out_ms_md_qid, s_rd);
      end
      n_tests++;
      if (q3.size() != 1) begin
         n_fail++;
         $display("FAIL reset_no_pop q3_size=%0d exp=1", q3.size());
      end
`ifdef MS_RC_SHAPING_EN
      n_tests++;
      if (dut.u_bucket.o_tokens !== 7'(TMAX)) begin
         n_fail++;
         $display("FAIL reset_tokens got=%0d exp=%0d", dut.u_bucket.o_tokens, TMAX);
      end
`endif
      rst_n = 1'b1;
      run_cycle();
      n_tests++;
      if (q3.size() != 0) begin
         n_fail++;
         $display("FAIL first_pop q3_size=%0d exp=0", q3.size());
      end
   endtask

   // slot queue beats q3; q3 left untouched until the next IDLE
   task automatic test_tsn_priority();
      do_reset();
      in_ms_time_slot_flag = 1'b1;
      q0.push_back(16'h00A5);
      q3.push_back(16'h0133);
      drive_heads();
      for (int k = 0; k < 10 && dut_log.size() < 1; k++) run_cycle();
      n_tests++;
      if (dut_log.size() != 1 || dut_log[0] != 0 || q3.size() != 1) begin
         n_fail++;
         $display("FAIL tsn_first log_size=%0d q3_size=%0d exp=1 entry qid0, q3 kept", dut_log.size(), q3.size());
      end
      in_ms_tx_done = 1'b1;
      for (int k = 0; k < 10 && dut_log.size() < 2; k++) run_cycle();
      n_tests++;
      if (dut_log.size() != 2 || dut_log[1] != 3) begin
         n_fail++;
         $display("FAIL tsn_then_q3 log_size=%0d exp=2 with qid3", dut_log.size());
      end
   endtask

   // wrong-parity slot queue is not eligible until the flag flips
   task automatic test_slot_gate();
      do_reset();
      in_ms_tx_done = 1'b1;
      in_ms_time_slot_flag = 1'b0;
      q0.push_back(16'h0042);
      drive_heads();
      repeat (6) run_cycle();
      n_tests++;
      if (q0.size() != 1 || dut_log.size() != 0) begin
         n_fail++;
         $display("FAIL slot_gate q0_size=%0d writes=%0d exp=1/0", q0.size(), dut_log.size());
      end
      in_ms_time_slot_flag = 1'b1;
      run_cycle();
      n_tests++;
      if (q0.size() != 0) begin
         n_fail++;
         $display("FAIL slot_flip q0_size=%0d exp=0", q0.size());
      end
      repeat (3) run_cycle();
   endtask

   task automatic test_q2_shaping();
      int exp_seq[$];
      do_reset();
      in_ms_tx_done = 1'b1;
      in_ms_time_slot_flag = 1'b0;
`ifdef MS_RC_SHAPING_EN
      q2.push_back({7'd117, 9'h011});
      q2.push_back({7'd12,  9'h022});
      q2.push_back({7'd0,   9'h033});
      q3.push_back(16'h0044);
      exp_seq = '{2, 3, 2, 2};
`else
      q2.push_back({7'd127, 9'h055});
      q3.push_back(16'h0066);
      exp_seq = '{2, 3};
`endif
      drive_heads();
      for (int k = 0; k < 80 && dut_log.size() < exp_seq.size(); k++) run_cycle();
      run_cycle();
      run_cycle();
      n_tests++;
      if (dut_log.size() != exp_seq.size()) begin
         n_fail++;
         $display("FAIL q2_order_len got=%0d exp=%0d", dut_log.size(), exp_seq.size());
      end else begin
         foreach (exp_seq[i]) begin
            n_tests++;
            if (dut_log[i] != exp_seq[i]) begin
               n_fail++;
               $display("FAIL q2_order[%0d] got=%0d exp=%0d", i, dut_log[i], exp_seq[i]);
            end
         end
      end
`ifdef MS_RC_SHAPING_EN
      n_tests++;
      if (dut.u_bucket.o_tokens !== 7'd0) begin
         n_fail++;
         $display("FAIL ptp_tokens got=%0d exp=0", dut.u_bucket.o_tokens);
      end
`endif
   endtask

   // tx_done during SEND must not release the block
   task automatic test_tx_done_ignore();
      int k;
      do_reset();
      in_ms_tx_done = 1'b0;
      q3.push_back(16'h0101);
      q3.push_back(16'h0102);
      drive_heads();
      s_rd = 4'b0000;
      for (k = 0; k < 10 && s_rd == 4'b0000; k++) run_cycle();
      in_ms_tx_done = 1'b1;
      run_cycle();
      n_tests++;
      if (s_wr !== 1'b1) begin
         n_fail++;
         $display("FAIL send_cycle wr=%b exp=1", s_wr);
      end
      in_ms_tx_done = 1'b0;
      repeat (4) run_cycle();
      n_tests++;
      if (q3.size() != 1 || dut_log.size() != 1) begin
         n_fail++;
         $display("FAIL done_ignored q3_size=%0d writes=%0d exp=1/1", q3.size(), dut_log.size());
      end
      in_ms_tx_done = 1'b1;
      run_cycle();
      in_ms_tx_done = 1'b0;
      run_cycle();
      n_tests++;
      if (q3.size() != 0) begin
         n_fail++;
         $display("FAIL done_release q3_size=%0d exp=0", q3.size());
      end
      repeat (2) run_cycle();
   endtask

   // reset while waiting abandons the transfer cleanly
   task automatic test_reset_wait();
      do_reset();
      in_ms_tx_done = 1'b0;
      in_ms_time_slot_flag = 1'b1;
      q0.push_back(16'h01F0);
      drive_heads();
      for (int k = 0; k < 10 && dut_log.size() < 1; k++) run_cycle();
      run_cycle();
      rst_n = 1'b0;
      q3.push_back(16'h010F);
      drive_heads();
      run_cycle();
      run_cycle();
      n_tests++;
      if ({out_ms_md_wr, out_ms_md, out_ms_md_qid} !== 12'h000 || q3.size() != 1) begin
         n_fail++;
         $display("FAIL wait_reset wr=%b md=%h qid=%0d q3_size=%0d exp=zeros/1", out_ms_md_wr, out_ms_md, out_ms_md_qid, q3.size());
      end
`ifdef MS_RC_SHAPING_EN
      n_tests++;
      if (dut.u_bucket.o_tokens !== 7'(TMAX)) begin
         n_fail++;
         $display("FAIL wait_reset_tokens got=%0d exp=%0d", dut.u_bucket.o_tokens, TMAX);
      end
`endif
      rst_n = 1'b1;
      repeat (6) run_cycle();
      n_tests++;
      if (dut_log.size() != 2 || q3.size() != 0) begin
         n_fail++;
         $display("FAIL after_release writes=%0d q3_size=%0d exp=2/0", dut_log.size(), q3.size());
      end
   endtask

   // random traffic, slot flips, tx_done noise and occasional resets
   task automatic test_random();
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         if (q0.size() < 4 && $urandom_range(0, 5) == 0) q0.push_back({7'd0, 9'($urandom)});
         if (q1.size() < 4 && $urandom_range(0, 5) == 0) q1.push_back({7'd0, 9'($urandom)});
`ifdef MS_RC_SHAPING_EN
         if (q2.size() < 4 && $urandom_range(0, 3) == 0) q2.push_back({7'($urandom_range(0, 40)), 9'($urandom)});
`else
         if (q2.size() < 4 && $urandom_range(0, 3) == 0) q2.push_back({7'($urandom_range(0, 127)), 9'($urandom)});
`endif
         if (q3.size() < 4 && $urandom_range(0, 3) == 0) q3.push_back({7'd0, 9'($urandom)});
         if ($urandom_range(0, 7) == 0) in_ms_time_slot_flag = ~in_ms_time_slot_flag;
         in_ms_tx_done = ($urandom_range(0, 2) == 0);
         rst_n = ($urandom_range(0, 299) != 0);
         drive_heads();
         run_cycle();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      rst_n = 1'b0;
      in_ms_time_slot_flag = 1'b0;
      in_ms_tx_done = 1'b0;
      s_rd = 4'b0000;
      s_wr = 1'b0;
      drive_heads();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_tsn_priority();
      test_slot_gate();
      test_q2_shaping();
      test_tx_done_ignore();
      test_reset_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time=%0t exp=finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 Parameter PLATFORM, default "xilinx", target FPGA family tag.
REQ-002 Parameter TOKEN_MAX, default 127, token bucket saturation level (7-bit units).
REQ-003 Parameter TOKEN_PERIOD, default 16, clocks per one-token refill.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 in_ms_time_slot_flag  in  1  current slot parity (0 even, 1 odd).
REQ-008 in_ms_md0_empty / in_ms_md1_empty / in_ms_md2_empty / in_ms_md3_empty  in  1 each  FWFT queue empty flags.
REQ-009 in_ms_md0, in_ms_md1, in_ms_md3  in  9 each; in_ms_md2  in  16  FWFT head data.
REQ-010 out_ms_md0_rd .. out_ms_md3_rd  out  1 each  queue pop strobes.
REQ-011 out_ms_md  out  9  selected metadata; out_ms_md_wr  out  1  valid pulse; out_ms_md_qid  out  2  source queue.
REQ-012 in_ms_tx_done  in  1  output port finished current packet.

Function
REQ-013 FSM states SHALL be IDLE, SEND, WAIT.
REQ-014 Eligibility: q0 when flag=1 and !md0_empty; q1 when flag=0 and !md1_empty; q2 when !md2_empty and tokens >= md2[15:9]; q3 when !md3_empty.
REQ-015 Priority SHALL be strict: eligible slot TSN queue (q0/q1) > q2 > q3.
REQ-016 In IDLE with any queue eligible, the block SHALL assert exactly one out_ms_mdX_rd for one cycle, latch head[8:0] and qid, and go to SEND.
REQ-017 In SEND, out_ms_md_wr SHALL be 1 for exactly one cycle with latched data; next state WAIT.
REQ-018 In WAIT, the block SHALL return to IDLE the cycle after in_ms_tx_done=1; tx_done outside WAIT SHALL be ignored.
REQ-019 Pop-to-wr latency SHALL be one cycle; no pop SHALL occur outside IDLE.
REQ-020 Slot flag toggling in SEND/WAIT SHALL NOT abort the transfer; new parity applies at next IDLE evaluation.
REQ-021 Token counter (7 bits) SHALL increment by 1 every TOKEN_PERIOD clocks, saturating at TOKEN_MAX.
REQ-022 On a q2 pop the counter SHALL subtract md2[15:9]; refill and pop in same cycle SHALL yield tokens - cost + 1, saturating at TOKEN_MAX.
REQ-023 Cost 0 (PTP) SHALL always satisfy eligibility when q2 non-empty.
REQ-024 out_ms_md and out_ms_md_qid SHALL hold last value outside SEND; out_ms_md_wr and all rd strobes SHALL be 0 outside their defined cycles.

Reset
REQ-025 With rst_n=0 at a clock edge: state IDLE, all outputs 0, token counter = TOKEN_MAX, refill divider = 0.
REQ-026 Reset mid-SEND/WAIT SHALL abandon the transfer with no further wr or rd pulse.

Configuration
REQ-027 Macro MS_RC_SHAPING_EN: defined -> token bucket per REQ-021..023; undefined -> counter and divider removed, q2 eligible whenever non-empty.

Structure
REQ-028 Shared package SHALL hold FSM state encoding, qid constants (0..3) and TOKEN_W=7.
REQ-029 The token bucket SHALL be sub-module ms_token_bucket (inputs consume, cost; outputs tokens).

Verification
REQ-030 flag=1, q0 and q3 non-empty -> md0_rd pulse, next cycle wr with qid=0, q3 untouched.
REQ-031 flag=0, only q0 non-empty -> no pop; flag->1 -> q0 popped on next IDLE cycle.
REQ-032 tokens=10, md2 cost=12, q3 non-empty -> q3 served; after 2 refills q2 served, tokens=0.
REQ-033 md2 cost=0 with tokens=0 -> q2 served immediately, tokens stay 0.
REQ-034 tx_done pulsed during SEND -> ignored; block remains WAIT until next tx_done.
REQ-035 rst_n low during WAIT -> all outputs 0, tokens=TOKEN_MAX, no spurious rd/wr after release.
